// File: rtl/prim_arbiter_rr_lock.sv
// ============================================================================
// Module   : prim_arbiter_rr_lock
// Purpose  : N:1 round-robin arbiter with ready/valid sink and optional data
//            mux. A rotating priority pointer prevents starvation. A lock
//            freezes the decision while the sink back-pressures.
// Ports    : clk_i    - clock, rising edge
//            rst_ni   - asynchronous active-low reset
//            req_i    - per-port request (held until granted)
//            data_i   - per-port payload, unpacked [N]
//            last_i   - last beat of a burst (only with PRIM_ARB_BURST_EN)
//            gnt_o    - one-hot0 grant, asserted only in the accept cycle
//            idx_o    - index of the selected port
//            valid_o  - request presented to the sink
//            data_o   - payload of the selected port (all-ones if disabled)
//            ready_i  - sink ready
// Macro    : PRIM_ARB_BURST_EN - adds last_i; the selection is held on the
//            granted port until a beat with last_i = 1 is accepted.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module prim_arbiter_rr_lock #(
   parameter int N          = 8,
   parameter int DW         = 32,
   parameter int EnDataPort = 1,
   localparam int IdxW      = (N > 1) ? $clog2(N) : 1
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic [N-1:0]    req_i,
   input  logic [DW-1:0]   data_i [N],
`ifdef PRIM_ARB_BURST_EN
   input  logic            last_i,
`endif
   output logic [N-1:0]    gnt_o,
   output logic [IdxW-1:0] idx_o,
   output logic            valid_o,
   output logic [DW-1:0]   data_o,
   input  logic            ready_i
);

   // -------------------------------------------------------------------------
   // Payload mux (shared by both arbitration variants)
   // -------------------------------------------------------------------------
   if (EnDataPort != 0) begin : g_data
      assign data_o = data_i[idx_o];
   end else begin : g_nodata
      assign data_o = '1;
      logic unused_data;
      assign unused_data = ^data_i[0];
   end

   if (N == 1) begin : g_bypass
      // ----------------------------------------------------------------------
      // Single requester: nothing to arbitrate, no state.
      // ----------------------------------------------------------------------
      assign valid_o  = req_i[0];
      assign gnt_o[0] = req_i[0] & ready_i;
      assign idx_o    = '0;

      logic unused_bypass;
`ifdef PRIM_ARB_BURST_EN
      assign unused_bypass = clk_i ^ rst_ni ^ last_i;
`else
      assign unused_bypass = clk_i ^ rst_ni;
`endif
   end else begin : g_arb
      logic [IdxW-1:0] ptr_q,  ptr_d;
      logic [IdxW-1:0] lidx_q, lidx_d;
      logic            lock_q, lock_d;
      logic [IdxW-1:0] rr_idx;
      logic [IdxW-1:0] idx_inc;
      logic            held;
      logic            accept;
`ifdef PRIM_ARB_BURST_EN
      logic            burst_q, burst_d;
`endif

      // Round-robin scan starting at ptr_q. The wrap is done by subtraction
      // so ptr_q never needs to be a power of two.
      always_comb begin : p_scan
         int  j;
         logic found;
         rr_idx = '0;
         found  = 1'b0;
         j      = 0;
         for (int i = 0; i < N; i++) begin
            j = int'(ptr_q) + i;
            if (j >= N) begin
               j = j - N;
            end
            if (!found && req_i[j]) begin
               found  = 1'b1;
               rr_idx = IdxW'(j);
            end
         end
      end

      // The frozen decision only wins while its requester still asserts req;
      // a dropped request falls back to normal round-robin in the same cycle.
`ifdef PRIM_ARB_BURST_EN
      assign held = (lock_q | burst_q) & req_i[lidx_q];
`else
      assign held = lock_q & req_i[lidx_q];
`endif

      assign valid_o = |req_i;
      assign idx_o   = held ? lidx_q : rr_idx;
      assign accept  = valid_o & ready_i;
      assign gnt_o   = accept ? ({{(N-1){1'b0}}, 1'b1} << idx_o) : '0;
      assign idx_inc = (idx_o == IdxW'(N - 1)) ? '0 : idx_o + 1'b1;

      always_comb begin : p_next
         ptr_d  = ptr_q;
         lock_d = lock_q;
         lidx_d = lidx_q;
`ifdef PRIM_ARB_BURST_EN
         burst_d = burst_q;
`endif
         if (valid_o) begin
            if (ready_i) begin
`ifdef PRIM_ARB_BURST_EN
               lock_d = 1'b0;
               if (last_i) begin
                  burst_d = 1'b0;
                  ptr_d   = idx_inc;
               end else begin
                  // Mid-burst beat: keep the port, leave the pointer alone.
                  burst_d = 1'b1;
                  lidx_d  = idx_o;
               end
`else
               lock_d = 1'b0;
               ptr_d  = idx_inc;
`endif
            end else begin
               lock_d = 1'b1;
               lidx_d = idx_o;
            end
         end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin : p_regs
         if (!rst_ni) begin
            ptr_q  <= '0;
            lock_q <= 1'b0;
            lidx_q <= '0;
`ifdef PRIM_ARB_BURST_EN
            burst_q <= 1'b0;
`endif
         end else begin
            ptr_q  <= ptr_d;
            lock_q <= lock_d;
            lidx_q <= lidx_d;
`ifdef PRIM_ARB_BURST_EN
            burst_q <= burst_d;
`endif
         end
      end

`ifndef SYNTHESIS
      a_lock_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
         (lock_q && req_i[lidx_q]) |-> (idx_o == lidx_q));
`endif
   end

`ifndef SYNTHESIS
   a_gnt_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni)
      $onehot0(gnt_o));
   a_gnt_needs_handshake : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (|gnt_o) |-> (ready_i && valid_o));
   a_accept_grants_req : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (valid_o && ready_i) |-> (gnt_o[idx_o] && req_i[idx_o]));
   a_outputs_known : assert property (@(posedge clk_i) disable iff (!rst_ni)
      !$isunknown({valid_o, idx_o, gnt_o}));
`endif

endmodule

`default_nettype wire

// File: tb/tb_prim_arbiter_rr_lock.sv
// ============================================================================
// Module   : tb_prim_arbiter_rr_lock
// Purpose  : Self-checking bench for prim_arbiter_rr_lock (N=4, N=3 and, with
//            PRIM_ARB_BURST_EN, N=2). Expected results are queued as stimulus
//            is driven and compared when the outputs settle.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_prim_arbiter_rr_lock;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;

   logic [3:0] req4, gnt4;
   logic [7:0] d4 [4];
   logic [1:0] idx4;
   logic       v4, rdy4;
   logic [7:0] do4;

   logic [2:0] req3, gnt3;
   logic [7:0] d3 [3];
   logic [1:0] idx3;
   logic       v3, rdy3;
   logic [7:0] do3;

`ifdef PRIM_ARB_BURST_EN
   logic       last_one;
   logic [1:0] req2, gnt2;
   logic [7:0] d2 [2];
   logic       idx2, v2, rdy2, last2;
   logic [7:0] do2;
`endif

   prim_arbiter_rr_lock #(.N(4), .DW(8), .EnDataPort(1)) u_dut4 (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .req_i   (req4),
      .data_i  (d4),
`ifdef PRIM_ARB_BURST_EN
      .last_i  (last_one),
`endif
      .gnt_o   (gnt4),
      .idx_o   (idx4),
      .valid_o (v4),
      .data_o  (do4),
      .ready_i (rdy4)
   );

   prim_arbiter_rr_lock #(.N(3), .DW(8), .EnDataPort(1)) u_dut3 (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .req_i   (req3),
      .data_i  (d3),
`ifdef PRIM_ARB_BURST_EN
      .last_i  (last_one),
`endif
      .gnt_o   (gnt3),
      .idx_o   (idx3),
      .valid_o (v3),
      .data_o  (do3),
      .ready_i (rdy3)
   );

`ifdef PRIM_ARB_BURST_EN
   prim_arbiter_rr_lock #(.N(2), .DW(8), .EnDataPort(1)) u_dut2 (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .req_i   (req2),
      .data_i  (d2),
      .last_i  (last2),
      .gnt_o   (gnt2),
      .idx_o   (idx2),
      .valid_o (v2),
      .data_o  (do2),
      .ready_i (rdy2)
   );
`endif

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [3:0] gnt;
      logic [1:0] idx;
      logic       valid;
      logic [7:0] data;
   } exp_t;

   exp_t sb[$];

   // Reference state for the N=4 instance
   int m_ptr  = 0;
   int m_lidx = 0;
   bit m_lock = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int model_pick(input logic [3:0] req);
      if (m_lock && req[m_lidx]) return m_lidx;
      for (int k = 0; k < 4; k++) begin
         if (req[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
      end
      return 0;
   endfunction

   // One N=4 cycle: drive, queue model expectation, compare, advance model.
   task automatic step4(input logic [3:0] req, input logic rdy, input int exp_idx);
      exp_t e;
      int   k;
      @(negedge clk);
      req4 = req;
      rdy4 = rdy;
      for (int i = 0; i < 4; i++) d4[i] = 8'($urandom);
      k       = model_pick(req);
      e.valid = |req;
      e.idx   = 2'(k);
      e.gnt   = (|req && rdy) ? 4'(1 << k) : 4'b0000;
      e.data  = d4[k];
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      check("valid4", 32'(v4),   32'(e.valid));
      check("idx4",   32'(idx4), 32'(e.idx));
      check("gnt4",   32'(gnt4), 32'(e.gnt));
      check("data4",  32'(do4),  32'(e.data));
      if (exp_idx >= 0) check("idx4_plan", 32'(idx4), 32'(exp_idx));
      if (|req) begin
         if (rdy) begin
            m_ptr  = (k + 1) % 4;
            m_lock = 1'b0;
         end else begin
            m_lock = 1'b1;
            m_lidx = k;
         end
      end
   endtask

   task automatic step3(input logic [2:0] req, input logic rdy, input int exp_idx,
                        input logic [2:0] exp_gnt);
      exp_t e;
      @(negedge clk);
      req3 = req;
      rdy3 = rdy;
      e.valid = |req;
      e.idx   = 2'(exp_idx);
      e.gnt   = {1'b0, exp_gnt};
      e.data  = d3[exp_idx];
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      check("valid3", 32'(v3),   32'(e.valid));
      check("idx3",   32'(idx3), 32'(e.idx));
      check("gnt3",   32'(gnt3), 32'(e.gnt));
      check("data3",  32'(do3),  32'(e.data));
   endtask

`ifdef PRIM_ARB_BURST_EN
   task automatic step2(input logic [1:0] req, input logic rdy, input logic lst,
                        input logic [1:0] exp_gnt);
      exp_t e;
      @(negedge clk);
      req2  = req;
      rdy2  = rdy;
      last2 = lst;
      e.gnt = {2'b00, exp_gnt};
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      check("gnt2_burst", 32'(gnt2), 32'(e.gnt));
   endtask
`endif

   // Reset pulse with all requests idle; outputs checked while reset is low.
   task automatic do_reset();
      @(negedge clk);
      req4 = '0;
      req3 = '0;
`ifdef PRIM_ARB_BURST_EN
      req2 = '0;
`endif
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_valid4", 32'(v4),   32'd0);
      check("rst_gnt4",   32'(gnt4), 32'd0);
      check("rst_idx4",   32'(idx4), 32'd0);
      check("rst_data4",  32'(do4),  32'(d4[0]));
      check("rst_valid3", 32'(v3),   32'd0);
      check("rst_gnt3",   32'(gnt3), 32'd0);
      m_ptr  = 0;
      m_lock = 1'b0;
      m_lidx = 0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b1;
      req4  = '0;
      rdy4  = 1'b0;
      req3  = '0;
      rdy3  = 1'b0;
      for (int i = 0; i < 4; i++) d4[i] = 8'hA0 + 8'(i);
      for (int i = 0; i < 3; i++) d3[i] = 8'h30 + 8'(i);
`ifdef PRIM_ARB_BURST_EN
      last_one = 1'b1;
      req2     = '0;
      rdy2     = 1'b0;
      last2    = 1'b1;
      d2[0]    = 8'h20;
      d2[1]    = 8'h21;
`endif
      do_reset();

      // Full request rotation
      for (int c = 0; c < 8; c++) step4(4'b1111, 1'b1, c % 4);
      step4(4'b0000, 1'b1, 0);

      // Pointer at 2, requests below it
      step4(4'b0010, 1'b1, 1);
      step4(4'b0011, 1'b1, 0);
      step4(4'b0011, 1'b1, 1);

      // Stall on 2 with port 0 joining; accept, then port 0
      step4(4'b0100, 1'b0, 2);
      step4(4'b0101, 1'b0, 2);
      step4(4'b0101, 1'b0, 2);
      step4(4'b0101, 1'b1, 2);
      step4(4'b0001, 1'b1, 0);

      // Lock holds against a higher-priority newcomer (pointer is 1)
      step4(4'b1000, 1'b0, 3);
      step4(4'b1010, 1'b0, 3);
      step4(4'b1010, 1'b1, 3);

      // Locked requester drops: fall back to round-robin, relock on new index
      step4(4'b0010, 1'b0, 1);
      step4(4'b1100, 1'b0, 2);
      step4(4'b1110, 1'b0, 2);
      step4(4'b1110, 1'b1, 2);

      // Reset in the middle of a stall on index 3
      step4(4'b1000, 1'b0, 3);
      do_reset();
      step4(4'b1001, 1'b1, 0);
      step4(4'b1000, 1'b1, 3);
      step4(4'b1001, 1'b1, 0);

      // Random traffic against the reference model
      for (int c = 0; c < 60; c++) step4(4'($urandom), 1'($urandom_range(0, 1)), -1);

      // Non-power-of-two wrap
      @(negedge clk);
      req4 = '0;
      do_reset();
      step3(3'b100, 1'b1, 2, 3'b100);
      step3(3'b111, 1'b1, 0, 3'b001);
      step3(3'b111, 1'b1, 1, 3'b010);
      step3(3'b111, 1'b1, 2, 3'b100);
      step3(3'b111, 1'b0, 0, 3'b000);
      step3(3'b111, 1'b1, 0, 3'b001);
      step3(3'b000, 1'b1, 0, 3'b000);

`ifdef PRIM_ARB_BURST_EN
      @(negedge clk);
      req3 = '0;
      do_reset();
      step2(2'b11, 1'b1, 1'b0, 2'b01);
      step2(2'b11, 1'b1, 1'b0, 2'b01);
      step2(2'b11, 1'b1, 1'b1, 2'b01);
      step2(2'b11, 1'b1, 1'b1, 2'b10);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
